fifo_drain_serializer: RTL and testbench
========================================

# fifo_drain_serializer

Drains a first-word-fall-through FIFO (fifo_fwft style: dout/empty/rd_en) and serializes each WIDTH-bit word into WIDTH/LINK_WIDTH narrow beats on a valid/ready link, MSB slice first, with a last-beat marker per word. It is the read-side counterpart to the producers that fill fifo_fwft. It sits between a message FIFO and the narrow inter-FPGA/inter-tile link of the QEC decoder fabric.

## Interface
- WIDTH, 16, FIFO word width in bits.
- LINK_WIDTH, 4, link beat width; WIDTH must be an exact multiple (elaboration error otherwise).
- CNT_WIDTH, 16, width of the sent-word counter.

- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_dout  in  WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  WIDTH→1  pop strobe, combinational, 1 bit.
- tx_data  out  LINK_WIDTH  current beat.
- tx_valid  out  1  beat valid.
- tx_last  out  1  high on the final beat of a word.
- tx_ready  in  1  downstream accept.
- words_sent  out  CNT_WIDTH  count of fully transmitted words, wraps modulo 2^CNT_WIDTH.
- busy  out  1  high while a word is held (state SEND).

## Operation
- BEATS = WIDTH/LINK_WIDTH. Registers: state {IDLE, SEND}, shift register sh[WIDTH-1:0], beat counter bcnt (clog2(BEATS), min 1 bit), words_sent.
- IDLE: tx_valid=0. If fifo_empty=0: fifo_rd_en=1, sh<=fifo_dout, bcnt<=0, go SEND.
- SEND: tx_valid=1, tx_data=sh[WIDTH-1 -: LINK_WIDTH], tx_last=(bcnt==BEATS-1).
  - Handshake (tx_valid&tx_ready), not last: sh<=sh<<LINK_WIDTH, bcnt++.
  - Handshake on last beat: words_sent++; if fifo_empty=0, fifo_rd_en=1, sh<=fifo_dout, bcnt<=0, stay SEND (no bubble); else go IDLE.
  - No handshake: sh, bcnt, tx_data held stable (AXI-style: valid never drops before accept).
- fifo_rd_en = !fifo_empty && (state==IDLE || (state==SEND && tx_ready && bcnt==BEATS-1)); never asserted when fifo_empty=1.
- BEATS==1: every beat is last; one word per accepted cycle.
- words_sent wraps from all-ones to 0 without flag.

## Timing
- Reset (reset_n=0, immediate): state=IDLE, sh=0, bcnt=0, words_sent=0; tx_valid=0, tx_last=0, tx_data=0, busy=0. fifo_rd_en=0 while in reset.
- Latency: fifo_empty falls at cycle t (IDLE) → pop at edge t, first beat valid from cycle t+1.
- Sustained throughput with tx_ready=1 and non-empty FIFO: one beat per cycle, one word per BEATS cycles, no idle cycles between words.
- tx_ready low stalls indefinitely; no pop occurs during stall.
- FIFO becomes non-empty in the same cycle the last beat is accepted: popped in that cycle (back-to-back).
- Reset mid-word: partially sent word is discarded (already popped); after release, next word starts at beat 0.
- tx_ready is not used combinationally for tx_valid; only fifo_rd_en depends combinationally on tx_ready and fifo_empty.

## Structure
- Shared package/header (parameters.v): default LINK_WIDTH, state encoding constants ST_IDLE/ST_SEND.
- Single flat module; no sub-module needed. Instantiated alongside fifo_fwft in the link wrapper.

## Test plan
- Reset: hold reset_n=0 with fifo_empty=0 → fifo_rd_en=0, tx_valid=0, words_sent=0; release → pop on first edge, tx_valid next cycle.
- Single word 16'hA5C3, tx_ready=1 → beats A,5,C,3 on consecutive cycles, tx_last only on 3, words_sent=1, then tx_valid=0.
- Back-to-back words 16'h1234, 16'h5678 queued, tx_ready=1 → 8 consecutive beats 1..8, exactly two pops, tx_last on beats 4 and 8, no gap cycle.
- Backpressure: word 16'hBEEF, tx_ready low for 3 cycles at beat 2 → tx_data=E held stable all 3 cycles, no pop, sequence B,E,E,F completes after release.
- Reset mid-word: assert reset_n=0 after beat 2 of 16'hCAFE with 16'h0F0F queued → outputs clear asynchronously; after release next beats are 0,F,0,F.
- Counter wrap (CNT_WIDTH=2): send 5 words → words_sent sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_drain_serializer_pkg.sv
// Shared definitions for the FIFO drain serializer: default widths, the
// controller state encoding and a helper for sizing the beat counter.
package fifo_drain_serializer_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_LINK_WIDTH = 4;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    // IDLE: nothing held. SEND: a popped word is being shifted out.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Beat counter width: enough to index every beat of a word, never 0 bits.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_drain_serializer.sv
// Drains a first-word-fall-through FIFO and serializes each WIDTH-bit word
// into WIDTH/LINK_WIDTH beats on a valid/ready link, MSB slice first, with
// tx_last marking the final beat of every word. When the last beat of a word
// is accepted and the FIFO still holds data, the next word is popped in the
// same cycle so the link sees no bubble between words.
module fifo_drain_serializer
    import fifo_drain_serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LINK_WIDTH = DEFAULT_LINK_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [LINK_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic [CNT_WIDTH-1:0]  words_sent,
    output logic                  busy
);

    localparam int                BEATS     = WIDTH / LINK_WIDTH;
    localparam int                BCNT_W    = beat_cnt_width(BEATS);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    // A word that does not split evenly into link beats is a wiring mistake.
    generate
        if (LINK_WIDTH < 1 || (WIDTH % LINK_WIDTH) != 0) begin : g_bad_width
            $error("fifo_drain_serializer: WIDTH must be a multiple of LINK_WIDTH");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_sh;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [CNT_WIDTH-1:0]  r_words_sent;

    logic                  w_on_last;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_word_done;

    assign w_on_last = (r_state == ST_SEND) && (r_bcnt == LAST_BEAT);

    // Next-state and datapath strobes: pop when idle, or when the final beat
    // of the held word is accepted and another word is waiting.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves one unassigned (which would infer a latch).
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (r_bcnt == LAST_BEAT) begin
                        w_word_done = 1'b1;
                        if (!fifo_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift register, beat counter and sent-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh         <= '0;
            r_bcnt       <= '0;
            r_words_sent <= '0;
        end else begin
            if (w_load) begin
                r_sh   <= fifo_dout;
                r_bcnt <= '0;
            end else if (w_shift) begin
                r_sh   <= r_sh << LINK_WIDTH;
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
            if (w_word_done) begin
                r_words_sent <= r_words_sent + CNT_WIDTH'(1);
            end
        end
    end

    // The pop strobe is held off while reset is asserted even though the
    // idle state would otherwise request a pop on a non-empty FIFO.
    assign fifo_rd_en = w_load && reset_n;
    assign tx_valid   = (r_state == ST_SEND);
    assign busy       = (r_state == ST_SEND);
    assign tx_last    = w_on_last;
    assign tx_data    = r_sh[WIDTH-1 -: LINK_WIDTH];
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Self-checking bench for fifo_drain_serializer. A queue models the FWFT
// FIFO; a scoreboard derives the expected beat stream from the popped words
// and checks every cycle, while directed tasks check the scenarios of
// interest inline.
module tb_fifo_drain_serializer;

    localparam int W     = 16;
    localparam int LW    = 4;
    localparam int CW    = 2;
    localparam int BEATS = W / LW;

    typedef struct packed {
        logic [LW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [LW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready;
    logic [CW-1:0] words_sent;
    logic          busy;

    int checks;
    int errors;

    fifo_drain_serializer #(
        .WIDTH      (W),
        .LINK_WIDTH (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .words_sent (words_sent),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FWFT FIFO model ----------------
    logic [W-1:0] fifo_q[$];
    logic         do_pop;

    always @(posedge clk) begin
        do_pop = reset_n && fifo_rd_en;
        #1;
        if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    end

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
        fifo_dout  = fifo_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- Scoreboard ----------------
    // Expected beats of every popped but not yet fully sent word.
    beat_t         exp_q[$];
    logic [CW-1:0] exp_words;
    logic          prev_stall;
    logic [LW-1:0] prev_data;
    logic          exp_rd;
    beat_t         b;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_words  = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL sb_stall_hold got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, prev_data);
                end
            end
            checks++;
            if (words_sent !== exp_words) begin
                errors++;
                $display("FAIL sb_words_sent got %0d exp %0d", words_sent, exp_words);
            end
            checks++;
            if (tx_valid !== (exp_q.size() > 0) || busy !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL sb_valid_busy got v=%b busy=%b exp %b", tx_valid, busy, exp_q.size() > 0);
            end
            // Pop when nothing is in flight, or when the only remaining beat
            // of the in-flight word is accepted now.
            exp_rd = !fifo_empty && (exp_q.size() == 0 || (tx_ready && exp_q.size() == 1));
            checks++;
            if (fifo_rd_en !== exp_rd) begin
                errors++;
                $display("FAIL sb_rd_en got %b exp %b", fifo_rd_en, exp_rd);
            end
            if (tx_valid && tx_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                checks++;
                if (tx_data !== b.d || tx_last !== b.l) begin
                    errors++;
                    $display("FAIL sb_beat got d=%h last=%b exp d=%h last=%b", tx_data, tx_last, b.d, b.l);
                end
                if (b.l) exp_words = exp_words + CW'(1);
            end
            if (fifo_rd_en && !fifo_empty) begin
                for (int k = 0; k < BEATS; k++) begin
                    exp_q.push_back('{d: fifo_dout[W-1-k*LW -: LW], l: (k == BEATS - 1)});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // ---------------- Collection helper ----------------
    logic [63:0] got_vec;
    logic [15:0] got_lv;
    int          got_n;
    logic [15:0] ws_vec;
    int          ws_n;
    int          pops;
    int          nvalid;
    int          first_i;
    int          last_i;
    int          st_pops;
    int          st_bad;
    logic [CW-1:0] ws_prev;

    // Runs n cycles; tx_ready is low for cycles [st_start, st_start+st_len).
    task automatic collect(input int n, input int st_start, input int st_len,
                           input logic [LW-1:0] st_exp);
        logic stalled;
        got_vec = '0; got_lv = '0; got_n = 0; ws_vec = '0; ws_n = 0;
        pops = 0; nvalid = 0; first_i = -1; last_i = -1; st_pops = 0; st_bad = 0;
        ws_prev = words_sent;
        for (int i = 0; i < n; i++) begin
            stalled  = (i >= st_start) && (i < st_start + st_len);
            tx_ready = !stalled;
            @(negedge clk);
            if (fifo_rd_en) pops++;
            if (tx_valid) begin
                nvalid++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
            if (stalled) begin
                if (fifo_rd_en) st_pops++;
                if (tx_valid !== 1'b1 || tx_data !== st_exp) st_bad++;
            end
            if (tx_valid && tx_ready) begin
                got_vec = {got_vec[59:0], tx_data};
                got_lv  = {got_lv[14:0], tx_last};
                got_n++;
            end
            if (words_sent !== ws_prev) begin
                ws_vec = {ws_vec[13:0], words_sent};
                ws_n++;
                ws_prev = words_sent;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        tx_ready = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        @(negedge clk);
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        logic [W-1:0] w;
        w        = W'($urandom);
        reset_n  = 1'b0;
        tx_ready = 1'b1;
        fifo_q.delete();
        push_word(w);
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || tx_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rd=%b v=%b busy=%b last=%b exp all 0", fifo_rd_en, tx_valid, busy, tx_last);
        end
        checks++;
        if (words_sent !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_data got ws=%0d d=%h exp 0 0", words_sent, tx_data);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pop got rd=%b v=%b exp rd=1 v=0", fifo_rd_en, tx_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== w[W-1 -: LW]) begin
            errors++;
            $display("FAIL reset_first_beat got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, w[W-1 -: LW]);
        end
        repeat (6) tick();
    endtask

    task automatic test_single();
        apply_reset();
        push_word(16'hA5C3);
        collect(8, 8, 0, '0);
        checks++;
        if (got_n !== 4 || got_vec !== 64'hA5C3 || got_lv !== 16'b0001) begin
            errors++;
            $display("FAIL single_beats got n=%0d d=%h l=%b exp n=4 d=a5c3 l=0001", got_n, got_vec, got_lv);
        end
        checks++;
        if (words_sent !== CW'(1) || pops !== 1) begin
            errors++;
            $display("FAIL single_count got ws=%0d pops=%0d exp 1 1", words_sent, pops);
        end
        checks++;
        if (nvalid !== 4 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got nvalid=%0d v=%b exp 4 0", nvalid, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push_word(16'h1234);
        push_word(16'h5678);
        collect(12, 12, 0, '0);
        checks++;
        if (got_n !== 8 || got_vec !== 64'h12345678 || got_lv !== 16'b00010001) begin
            errors++;
            $display("FAIL b2b_beats got n=%0d d=%h l=%b exp n=8 d=12345678 l=00010001", got_n, got_vec, got_lv);
        end
        checks++;
        if (pops !== 2 || (last_i - first_i + 1) !== nvalid) begin
            errors++;
            $display("FAIL b2b_no_gap got pops=%0d span=%0d valid=%0d exp pops=2 span=valid",
                     pops, last_i - first_i + 1, nvalid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_word(16'hBEEF);
        push_word(16'h1357);
        collect(14, 2, 3, 4'hE);
        checks++;
        if (st_bad !== 0 || st_pops !== 0) begin
            errors++;
            $display("FAIL bp_stall got bad=%0d pops=%0d exp 0 0", st_bad, st_pops);
        end
        checks++;
        if (got_n !== 8 || got_vec !== 64'hBEEF1357 || got_lv !== 16'b00010001) begin
            errors++;
            $display("FAIL bp_beats got n=%0d d=%h l=%b exp n=8 d=beef1357 l=00010001", got_n, got_vec, got_lv);
        end
    endtask

    task automatic test_reset_mid_word();
        apply_reset();
        push_word(16'hCAFE);
        push_word(16'h0F0F);
        collect(3, 3, 0, '0);
        checks++;
        if (got_n !== 2 || got_vec !== 64'hCA) begin
            errors++;
            $display("FAIL rst_mid_pre got n=%0d d=%h exp 2 ca", got_n, got_vec);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_last !== 1'b0 || tx_data !== '0 ||
            words_sent !== '0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b busy=%b last=%b d=%h ws=%0d rd=%b exp all 0",
                     tx_valid, busy, tx_last, tx_data, words_sent, fifo_rd_en);
        end
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        collect(8, 8, 0, '0);
        checks++;
        if (got_n !== 4 || got_vec !== 64'h0F0F || got_lv !== 16'b0001 || pops !== 1) begin
            errors++;
            $display("FAIL rst_mid_next got n=%0d d=%h l=%b pops=%0d exp 4 0f0f 0001 1",
                     got_n, got_vec, got_lv, pops);
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 5; i++) push_word(W'($urandom));
        collect(25, 25, 0, '0);
        checks++;
        if (ws_n !== 5 || ws_vec !== 16'b01_10_11_00_01) begin
            errors++;
            $display("FAIL wrap_seq got n=%0d seq=%b exp 5 0110110001", ws_n, ws_vec);
        end
    endtask

    task automatic test_random();
        int n_pushed;
        apply_reset();
        n_pushed = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) begin
                push_word(W'($urandom));
                n_pushed++;
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        tx_ready = 1'b1;
        repeat (60) tick();
        @(negedge clk);
        checks++;
        if (fifo_q.size() !== 0 || tx_valid !== 1'b0 || words_sent !== CW'(n_pushed)) begin
            errors++;
            $display("FAIL random_drain got left=%0d v=%b ws=%0d exp 0 0 %0d",
                     fifo_q.size(), tx_valid, words_sent, CW'(n_pushed));
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        tx_ready   = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        prev_stall = 1'b0;
        exp_words  = '0;
        repeat (2) tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
